// File: rtl/fetch_sequencer_if.sv
// Memory read bus between the fetch sequencer (master) and the instruction RAM (slave).
// Carries the read request/address and the returned data with its ready strobe.
interface fetch_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_rd_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_rd_req,
        input  mem_addr,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute sequencer: reads instructions at pc, holds them for the datapath,
// halts on HALT_OP or a fetch timeout. Define FETCH_BRANCH_EN to add branch_take/branch_target.
module fetch_sequencer #(
    parameter int         DATA_W   = 32,
    parameter int         ADDR_W   = 16,
    parameter int         PC_STEP  = 1,
    parameter int         RESET_PC = 0,
    parameter logic [3:0] HALT_OP  = 4'hF,
    parameter int         WAIT_MAX = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    fetch_sequencer_if.master      mem,
    input  logic                   exec_done,
    input  logic                   stall,
`ifdef FETCH_BRANCH_EN
    input  logic                   branch_take,
    input  logic [ADDR_W-1:0]      branch_target,
`endif
    output logic [DATA_W-1:0]      instr,
    output logic                   instr_valid,
    output logic [ADDR_W-1:0]      pc,
    output logic [1:0]             state,
    output logic                   halt,
    output logic                   timeout_err
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DECODE  = 2'd1,
        S_EXECUTE = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    // Wide enough to hold WAIT_MAX itself; a disabled timeout still needs a 1-bit counter.
    localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                terr_q, terr_d;
    logic [ADDR_W-1:0]   retire_pc;

`ifdef FETCH_BRANCH_EN
    assign retire_pc = branch_take ? branch_target : pc_q + ADDR_W'(PC_STEP);
`else
    assign retire_pc = pc_q + ADDR_W'(PC_STEP);
`endif

    // NOTE: every register is written with <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= ADDR_W'(RESET_PC);
            instr_q <= '0;
            wait_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            wait_q  <= wait_d;
            terr_q  <= terr_d;
        end
    end

    // NOTE: defaults first, so any path that does not assign a value holds it and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        wait_d  = wait_q;
        terr_d  = terr_q;
        unique case (state_q)
            S_FETCH: begin
                if (!stall) begin
                    if (mem.mem_ready) begin
                        instr_d = mem.mem_rdata;
                        wait_d  = '0;
                        state_d = S_DECODE;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                        if (WAIT_MAX != 0 && int'(wait_q) + 1 == WAIT_MAX) begin
                            terr_d  = 1'b1;
                            state_d = S_HALT;
                        end
                    end
                end
            end
            S_DECODE: begin
                state_d = (instr_q[27:24] == HALT_OP) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                // A stall overrides a simultaneous exec_done.
                if (exec_done && !stall) begin
                    pc_d    = retire_pc;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
            end
            default: begin
            end
        endcase
    end

    assign mem.mem_rd_req = (state_q == S_FETCH) && !stall;
    assign mem.mem_addr   = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = (state_q == S_EXECUTE);
    assign pc             = pc_q;
    assign state          = state_q;
    assign halt           = (state_q == S_HALT);
    assign timeout_err    = terr_q;

endmodule
